// File: rtl/aes_link_pkg.sv
// Shared constants for the AES chip link: FSM state encoding and bus/block sizes.
package aes_link_pkg;
  localparam int BYTES_PER_BLOCK = 16;
  localparam int BUS_W           = 9;
  localparam int BLK_W           = 8 * BYTES_PER_BLOCK;

  localparam logic [1:0] ST_RX      = 2'd0;
  localparam logic [1:0] ST_DELIVER = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_TX      = 2'd3;
endpackage

// File: rtl/aes_link_if.sv
// Bundle of the platform byte link and the AES-core block handshake.
interface aes_link_if;
  import aes_link_pkg::*;

  logic [BUS_W-1:0] bus_in;
  logic [BUS_W-1:0] bus_out;
  logic [BLK_W-1:0] blk_data;
  logic             blk_valid;
  logic [BLK_W-1:0] res_data;
  logic             res_valid;
  logic             res_ready;
  logic             overrun;
  logic             busy;

  modport master (output bus_in, res_data, res_valid,
                  input  bus_out, blk_data, blk_valid, res_ready, overrun, busy);
  modport slave  (input  bus_in, res_data, res_valid,
                  output bus_out, blk_data, blk_valid, res_ready, overrun, busy);
endinterface

// File: rtl/aes_link_sync.sv
// Parameterized multi-bit flop-chain synchronizer with async active-low reset.
module aes_link_sync #(
  parameter int WIDTH  = 9,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/aes_chip_link.sv
// Byte-serial link between platform and AES core: assembles 16-byte blocks, returns results.
// Optional idle timeout for partial blocks is built only when AES_LINK_TIMEOUT_EN is defined.
module aes_chip_link
  import aes_link_pkg::*;
#(
  parameter int TX_HOLD     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input logic       clk,
  input logic       rst_n,
  aes_link_if.slave link
);
  if (TX_HOLD < 2 || TX_HOLD > 255 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT < 2)
  begin : g_bad_param
    $error("aes_chip_link: parameter out of legal range");
  end

  logic [BUS_W-1:0] bus_s;
  logic             tog_prev_q;
  logic             edge_det;
  logic             pend_q;
  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       hold_q, hold_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [BLK_W-1:0] res_q, res_d;
  logic [BUS_W-1:0] bus_out_q, bus_out_d;
  logic             overrun_q, overrun_d;

  aes_link_sync #(.WIDTH(BUS_W), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (link.bus_in),
    .q_o   (bus_s)
  );

  assign edge_det = bus_s[8] ^ tog_prev_q;

`ifdef AES_LINK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] idle_q;
  logic             tmo_hit;

  assign tmo_hit = (idle_q == TMO_W'(TIMEOUT - 1)) && !edge_det && !pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else if (state_q != ST_RX || cnt_q == 4'd0 || edge_det || pend_q || tmo_hit) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + 1'b1;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    blk_d     = blk_q;
    res_d     = res_q;
    bus_out_d = bus_out_q;
    overrun_d = overrun_q | (edge_det && state_q != ST_RX);
    case (state_q)
      ST_RX: begin
        if (pend_q) begin
          blk_d = {blk_q[BLK_W-9:0], bus_s[7:0]};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(BYTES_PER_BLOCK - 1)) state_d = ST_DELIVER;
        end
`ifdef AES_LINK_TIMEOUT_EN
        else if (tmo_hit) begin
          cnt_d = 4'd0;
        end
`endif
      end
      ST_DELIVER: state_d = ST_WAIT;
      ST_WAIT: begin
        if (link.res_valid) begin
          res_d     = {link.res_data[BLK_W-9:0], 8'h00};
          bus_out_d = {~bus_out_q[8], link.res_data[BLK_W-1 -: 8]};
          hold_d    = 8'd0;
          cnt_d     = 4'd0;
          state_d   = ST_TX;
        end
      end
      default: begin
        // cnt_q indexes the byte currently on the bus; the last byte's hold ends the block
        if (hold_q == 8'(TX_HOLD - 1)) begin
          hold_d = 8'd0;
          if (cnt_q == 4'(BYTES_PER_BLOCK - 1)) begin
            cnt_d   = 4'd0;
            state_d = ST_RX;
          end else begin
            bus_out_d = {~bus_out_q[8], res_q[BLK_W-1 -: 8]};
            res_d     = {res_q[BLK_W-9:0], 8'h00};
            cnt_d     = cnt_q + 4'd1;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_prev_q <= 1'b0;
      pend_q     <= 1'b0;
      state_q    <= ST_RX;
      cnt_q      <= 4'd0;
      hold_q     <= 8'd0;
      blk_q      <= '0;
      res_q      <= '0;
      bus_out_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      tog_prev_q <= bus_s[8];
      pend_q     <= edge_det && (state_q == ST_RX);
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      blk_q      <= blk_d;
      res_q      <= res_d;
      bus_out_q  <= bus_out_d;
      overrun_q  <= overrun_d;
    end
  end

  assign link.bus_out   = bus_out_q;
  assign link.blk_data  = blk_q;
  assign link.blk_valid = (state_q == ST_DELIVER);
  assign link.res_ready = (state_q == ST_WAIT);
  assign link.overrun   = overrun_q;
  assign link.busy      = !(state_q == ST_RX && cnt_q == 4'd0);
endmodule

// File: doc/aes_chip_link.md
AES_CHIP_LINK -- requirements
Module: aes_chip_link

Interface
REQ-001 Parameter TX_HOLD, default 4: clk cycles each outbound byte is held on bus_out (legal 2..255).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on bus_in (legal 2..4).
REQ-003 Parameter TIMEOUT, default 1024: idle-cycle limit for partial block abort (used only under AES_LINK_TIMEOUT_EN).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, named exactly as below.
REQ-005 clk  in  1  core clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 bus_in  in  9  link from platform: [7:0] byte, [8] toggle strobe (each toggle = one new byte).
REQ-008 bus_out  out  9  link to platform: [7:0] byte, [8] toggle strobe.
REQ-009 blk_data  out  128  assembled inbound block; first byte received in [127:120].
REQ-010 blk_valid  out  1  one-cycle pulse, blk_data complete.
REQ-011 res_data  in  128  result block from AES core; [127:120] sent first.
REQ-012 res_valid  in  1  result offered.
REQ-013 res_ready  out  1  high only in WAIT_RES; transfer when res_valid&res_ready.
REQ-014 overrun  out  1  sticky: inbound toggle seen outside RX state.
REQ-015 busy  out  1  high in any state other than RX with byte count 0.

Function
REQ-016 All 9 bus_in bits SHALL pass through SYNC_STAGES flops; toggle edge = synchronized bit8 differs from its previous registered value.
REQ-017 Byte SHALL be captured from synchronized [7:0] one cycle after toggle edge detection.
REQ-018 States: RX, DELIVER, WAIT_RES, TX.
REQ-019 RX: each captured byte shifts into blk_data MSB-first; 4-bit count increments; 16th byte -> DELIVER.
REQ-020 DELIVER: blk_valid=1 for exactly one cycle, blk_data stable; next cycle -> WAIT_RES.
REQ-021 WAIT_RES: res_ready=1; on res_valid the 128-bit result SHALL be latched and state -> TX.
REQ-022 TX: first byte plus bit8 toggle appear on bus_out the cycle after handshake; each byte held TX_HOLD cycles; after 16th byte's hold -> RX, count=0.
REQ-023 bus_out SHALL change only at byte boundaries; [7:0] and [8] update in the same cycle.
REQ-024 Toggles detected in DELIVER/WAIT_RES/TX SHALL be dropped and set overrun; overrun cleared only by reset.
REQ-025 blk_data SHALL hold its value until the next block's first byte shifts in.
REQ-026 Toggle edge and 16th-byte completion same cycle: not possible by REQ-017 pipelining; count wrap 15->0 occurs on entry to DELIVER.

Reset
REQ-027 On rst_n low, immediately: state RX, count 0, bus_out 9'h000, blk_data 0, blk_valid 0, res_ready 0, overrun 0, busy 0, synchronizer flops 0.
REQ-028 Reset mid-block or mid-TX SHALL discard all partial data; no byte emitted after release until a new result is accepted.

Configuration
REQ-029 Macro AES_LINK_TIMEOUT_EN defined: in RX with count>0, TIMEOUT consecutive cycles without toggle edge SHALL reset count to 0 (partial block discarded, no blk_valid).
REQ-030 Macro absent: no timeout counter is built; a partial block waits indefinitely.

Structure
REQ-031 Shared package aes_link_pkg: state encoding, BYTES_PER_BLOCK=16, bus width 9.
REQ-032 One sub-module aes_link_sync (parameterized multi-bit synchronizer) is natural; rest in aes_chip_link.

Verification
REQ-033 Send 16 bytes 00..0F with toggles 8 cycles apart -> single blk_valid pulse, blk_data=128'h000102030405060708090A0B0C0D0E0F.
REQ-034 In WAIT_RES drive res_data=128'h69C4E0D86A7B0430D8CDB78070B4C55A, res_valid=1 -> res_ready drops next cycle; bus_out emits 69,C4,...,5A, bit8 toggling every TX_HOLD=4 cycles, 64 cycles total.
REQ-035 Inject a toggle during TX -> overrun=1, TX byte sequence unchanged, next block assembles correctly.
REQ-036 Assert rst_n low after 7 inbound bytes, release, send 16 bytes AA -> blk_data=all AA, no earlier bytes present.
REQ-037 With AES_LINK_TIMEOUT_EN, TIMEOUT=64: send 5 bytes, idle 100 cycles, send 16 bytes 11 -> exactly one blk_valid, blk_data=all 11.
REQ-038 Without macro, same stimulus -> blk_valid after the 11th byte of the second burst, blk_data containing the 5 earlier bytes first.
